// File: rtl/frame_sample_mixer.sv
// Mixes 1..MAX_SRC signed beats per frame into one held PCM sample (SUM/AVG/FIRST/MUTE); result registered 1 cycle after i_last.
// No backpressure: a beat is taken every cycle i_valid is high. Optional peak meter under `ifdef MIX_PEAK_EN.
module frame_sample_mixer #(
  parameter  int DATA_W  = 16,
  parameter  int MAX_SRC = 8,
  localparam int ACC_W   = DATA_W + $clog2(MAX_SRC) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic [1:0]        i_mode,
`ifdef MIX_PEAK_EN
  input  logic              i_peak_clr,
  output logic [DATA_W-2:0] o_peak,
`endif
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_clip,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(MAX_SRC + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {S_IDLE, S_ACC} state_t;
  typedef enum logic [1:0] {M_SUM, M_AVG, M_FIRST, M_MUTE} mode_t;

  state_t                   r_state, w_state_nxt;
  mode_t                    r_mode, w_mode_base;
  logic signed [ACC_W-1:0]  r_acc, w_acc_base, w_acc_nxt, w_beat, w_scaled;
  logic [CNT_W-1:0]         r_cnt, w_cnt_base, w_cnt_nxt;
  logic                     r_ovr, w_ovr_base, w_ovr_nxt;
  logic                     w_accept, w_fin, w_clip;
  logic [DATA_W-1:0]        w_res;
  logic [DATA_W-1:0]        r_data;
  logic                     r_valid, r_clip, r_overrun;

  function automatic logic [CNT_W-1:0] f_ceil_log2(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int k = 0; k < CNT_W; k++)
      if ((1 << k) < int'(c)) s = CNT_W'(k + 1);
    return s;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat      = {{(ACC_W - DATA_W){i_data[DATA_W-1]}}, i_data};
    // In idle the frame starts fresh, so the first beat sees an empty context and the live mode.
    if (r_state == S_IDLE) begin
      w_acc_base  = '0;
      w_cnt_base  = '0;
      w_ovr_base  = 1'b0;
      w_mode_base = mode_t'(i_mode);
    end else begin
      w_acc_base  = r_acc;
      w_cnt_base  = r_cnt;
      w_ovr_base  = r_ovr;
      w_mode_base = r_mode;
    end
    w_accept  = i_valid && (w_cnt_base < CNT_W'(MAX_SRC));
    w_fin     = i_valid && i_last;
    w_acc_nxt = w_acc_base;
    w_cnt_nxt = w_cnt_base;
    w_ovr_nxt = w_ovr_base;
    if (w_accept) begin
      w_cnt_nxt = w_cnt_base + 1'b1;
      if (!(w_mode_base == M_FIRST && w_cnt_base != '0))
        w_acc_nxt = w_acc_base + w_beat;
    end else if (i_valid) begin
      w_ovr_nxt = 1'b1;
    end
    case (r_state)
      S_IDLE:  if (i_valid && !i_last) w_state_nxt = S_ACC;
      S_ACC:   if (w_fin) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_scaled = (w_mode_base == M_AVG) ? (w_acc_nxt >>> f_ceil_log2(w_cnt_nxt)) : w_acc_nxt;
    w_clip   = 1'b0;
    w_res    = w_scaled[DATA_W-1:0];
    if (w_mode_base == M_MUTE) begin
      w_res = '0;
    end else if (w_scaled > SAT_MAX) begin
      w_res  = SAT_MAX[DATA_W-1:0];
      w_clip = 1'b1;
    end else if (w_scaled < SAT_MIN) begin
      w_res  = SAT_MIN[DATA_W-1:0];
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovr     <= 1'b0;
      r_mode    <= M_SUM;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_clip    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovr   <= w_ovr_nxt;
      r_mode  <= w_mode_base;
      r_valid <= w_fin;
      if (w_fin) begin
        r_data    <= w_res;
        r_clip    <= w_clip;
        r_overrun <= w_ovr_nxt;
      end
    end
  end

`ifdef MIX_PEAK_EN
  logic [DATA_W-1:0] w_neg;
  logic [DATA_W-2:0] w_mag, r_peak;

  // Negating the most negative sample overflows back to itself; its MSB marks the saturating case.
  always_comb begin
    w_neg = ~w_res + 1'b1;
    if (!w_res[DATA_W-1])     w_mag = w_res[DATA_W-2:0];
    else if (w_neg[DATA_W-1]) w_mag = '1;
    else                      w_mag = w_neg[DATA_W-2:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                          r_peak <= '0;
    else if (w_fin) begin
      if (i_peak_clr || w_mag > r_peak) r_peak <= w_mag;
    end else if (i_peak_clr)            r_peak <= '0;
  end

  assign o_peak = r_peak;
`endif

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_clip    = r_clip;
  assign o_overrun = r_overrun;
  assign o_busy    = (r_state == S_ACC);

endmodule

// File: tb/tb_frame_sample_mixer.sv
// Frame vectors from a table are driven back to back; expected results are queued and compared on o_valid.
module tb_frame_sample_mixer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic        i_last = 1'b0;
  logic [1:0]  i_mode = '0;
  logic [15:0] o_data;
  logic        o_valid, o_clip, o_overrun, o_busy;
`ifdef MIX_PEAK_EN
  logic        i_peak_clr = 1'b0;
  logic [14:0] o_peak;
`endif

  always #5 i_clk = ~i_clk;

  frame_sample_mixer #(.DATA_W(16), .MAX_SRC(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_last(i_last), .i_mode(i_mode),
`ifdef MIX_PEAK_EN
    .i_peak_clr(i_peak_clr), .o_peak(o_peak),
`endif
    .o_data(o_data), .o_valid(o_valid), .o_clip(o_clip),
    .o_overrun(o_overrun), .o_busy(o_busy)
  );

  typedef struct {
    string name;
    int    mode;
    int    mlate;
    int    n;
    int    b0, b1, rest;
    bit    gaps;
    int    exp_data;
    bit    exp_clip;
    bit    exp_ovr;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        clip;
    logic        ovr;
  } exp_t;

  vec_t vecs[17];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_o_valid", 32'(o_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".data"}, 32'(o_data), 32'(e.data));
        check({e.name, ".clip"}, 32'(o_clip), 32'(e.clip));
        check({e.name, ".ovr"},  32'(o_overrun), 32'(e.ovr));
      end
    end
  end

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_last  = 1'b0;
    end
  endtask

  task automatic send_frame(input vec_t v);
    for (int k = 0; k < v.n; k++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1;
      i_data  = 16'((k == 0) ? v.b0 : (k == 1) ? v.b1 : v.rest);
      i_last  = (k == v.n - 1);
      i_mode  = 2'((k == 0) ? v.mode : v.mlate);
      if (k == v.n - 1) exp_q.push_back('{v.name, 16'(v.exp_data), v.exp_clip, v.exp_ovr});
      else if (v.gaps) begin
        // Idle beat with junk data and i_last high must be ignored.
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_data  = 16'h5555;
        i_last  = 1'b1;
      end
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge i_clk);
    check("drain_pending_results", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t v;
    //          name                 mode mlate n  b0      b1      rest    gaps exp     clip ovr
    vecs[0]  = '{"sum_t1",             0, 0,  3, 1000,   2000,   -500,   0,   2500,   0, 0};
    vecs[1]  = '{"sum_pos_sat",        0, 0,  2, 28672,  28672,  0,      0,   32767,  1, 0};
    vecs[2]  = '{"sum_neg_sat",        0, 0,  2, -28672, -28672, 0,      0,   -32768, 1, 0};
    vecs[3]  = '{"avg3_late_sum",      1, 0,  3, 400,    400,    400,    0,   300,    0, 0};
    vecs[4]  = '{"avg1",               1, 1,  1, -123,   0,      0,      0,   -123,   0, 0};
    vecs[5]  = '{"sum_overrun",        0, 0, 10, 1,      1,      1,      0,   8,      0, 1};
    vecs[6]  = '{"sum_after_ovr",      0, 0,  1, 5,      0,      0,      0,   5,      0, 0};
    vecs[7]  = '{"avg2_gaps",          1, 1,  2, 100,    -300,   0,      1,   -100,   0, 0};
    vecs[8]  = '{"avg5_floor",         1, 1,  5, -7,     0,      0,      0,   -1,     0, 0};
    vecs[9]  = '{"first",              2, 2,  3, -42,    1000,   1000,   0,   -42,    0, 0};
    vecs[10] = '{"mute",               3, 3,  3, 28672,  28672,  28672,  0,   0,      0, 0};
    vecs[11] = '{"mute_ovr",           3, 3,  9, 1,      1,      1,      0,   0,      0, 1};
    vecs[12] = '{"avg8_max",           1, 1,  8, 32767,  32767,  32767,  0,   32767,  0, 0};
    vecs[13] = '{"sum8_min",           0, 0,  8, -32768, -32768, -32768, 0,   -32768, 1, 0};
    vecs[14] = '{"first_ovr_late",     2, 3,  9, 77,     -5,     -5,     0,   77,     0, 1};
    vecs[15] = '{"sum_late_avg_gaps",  0, 1,  2, 10,     20,     0,      1,   30,     0, 0};
    vecs[16] = '{"avg9_ovr",           1, 1,  9, 8,      8,      8,      0,   8,      0, 1};

    repeat (3) @(posedge i_clk);
    #1;
    check("rst.o_data",    32'(o_data),    32'd0);
    check("rst.o_valid",   32'(o_valid),   32'd0);
    check("rst.o_clip",    32'(o_clip),    32'd0);
    check("rst.o_overrun", 32'(o_overrun), 32'd0);
    check("rst.o_busy",    32'(o_busy),    32'd0);
    i_rst = 1'b0;

    // Busy must rise after the first non-last beat and fall once the frame completes.
    v = vecs[0];
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_data = 16'd1000; i_last = 1'b0; i_mode = 2'd0;
    @(negedge i_clk);
    check("busy_before_first_edge", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    check("busy_mid_frame", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_data = 16'd1500; i_last = 1'b1;
    exp_q.push_back('{"busy_frame", 16'd2500, 1'b0, 1'b0});
    idle(1);
    @(negedge i_clk);
    check("busy_after_frame", 32'(o_busy), 32'd0);

    foreach (vecs[i]) send_frame(vecs[i]);
    idle(1);
    drain();

    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    check("hold.o_data",    32'(o_data),    32'(16'(vecs[16].exp_data)));
    check("hold.o_overrun", 32'(o_overrun), 32'd1);
    check("hold.o_valid",   32'(o_valid),   32'd0);

    // Reset in the middle of a frame discards it and clears the held sample.
    for (int k = 0; k < 2; k++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_data = 16'd300; i_last = 1'b0; i_mode = 2'd0;
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("midrst.o_data",  32'(o_data),  32'd0);
    check("midrst.o_busy",  32'(o_busy),  32'd0);
    check("midrst.o_valid", 32'(o_valid), 32'd0);
    v = '{"after_midrst", 0, 0, 1, 5, 0, 0, 0, 5, 0, 0};
    send_frame(v);
    idle(1);
    drain();

`ifdef MIX_PEAK_EN
    @(posedge i_clk); #1; i_peak_clr = 1'b1;
    @(posedge i_clk); #1; i_peak_clr = 1'b0;
    v = '{"peak_m300", 0, 0, 1, -300, 0, 0, 0, -300, 0, 0};
    send_frame(v);
    v = '{"peak_200", 0, 0, 1, 200, 0, 0, 0, 200, 0, 0};
    send_frame(v);
    idle(2);
    drain();
    check("peak_300", 32'(o_peak), 32'd300);
    @(posedge i_clk); #1; i_peak_clr = 1'b1;
    @(posedge i_clk); #1; i_peak_clr = 1'b0;
    @(negedge i_clk);
    check("peak_cleared", 32'(o_peak), 32'd0);
    v = '{"peak_50", 0, 0, 1, 50, 0, 0, 0, 50, 0, 0};
    send_frame(v);
    idle(2);
    drain();
    check("peak_50", 32'(o_peak), 32'd50);
    v = '{"peak_min", 0, 0, 1, -32768, 0, 0, 0, -32768, 0, 0};
    send_frame(v);
    idle(2);
    drain();
    check("peak_min_sat", 32'(o_peak), 32'd32767);
    v = '{"peak_clr_same", 0, 0, 1, 10, 0, 0, 0, 10, 0, 0};
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_data = 16'd10; i_last = 1'b1; i_mode = 2'd0; i_peak_clr = 1'b1;
    exp_q.push_back('{v.name, 16'd10, 1'b0, 1'b0});
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_last = 1'b0; i_peak_clr = 1'b0;
    idle(1);
    drain();
    check("peak_clr_with_frame", 32'(o_peak), 32'd10);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
